memctrl_nport: RTL and testbench
================================

MEMCTRL_NPORT -- requirements
Module: memctrl_nport

Interface
REQ-001 SHALL have parameter NPORT, default 2: number of requester ports (1..4).
REQ-002 SHALL have parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority (port 0 highest).
REQ-003 SHALL have parameter IO_HI, default 2'b11: value of addr[17:16] marking the I/O region.
REQ-004 SHALL have one clock; reset is synchronous and active-high: clk_in input 1 system clock, rst_in input 1 reset.
REQ-005 SHALL have port: rdy_in  input  1  global enable; low freezes all state.
REQ-006 SHALL have port: clear  input  1  pipeline flush.
REQ-007 SHALL have port: mem_din  input  8  memory read data, valid one cycle after its address.
REQ-008 SHALL have ports: mem_dout output 8 write byte; mem_a output 32 byte address; mem_wr output 1 write strobe (1 = write).
REQ-009 SHALL have port: io_buffer_full  input  1  UART buffer full.
REQ-010 SHALL have ports: req_valid input NPORT; req_addr input 32*NPORT; req_wdata input 32*NPORT; req_type input 4*NPORT, per port {store, unsigned, size[1:0]}, size 0=byte, 1=half, 2/3=word.
REQ-011 SHALL have ports: resp_valid output NPORT one-hot completion pulse; resp_data output 32 load result.

Function
REQ-012 SHALL use states IDLE, XFER, TAIL; reset and clear (non-store) enter IDLE.
REQ-013 In IDLE, SHALL grant one eligible port per cycle; eligible = req_valid set and not (store && addr[17:16]==IO_HI && io_buffer_full); ineligible ports are skipped, not blocking.
REQ-014 RR=1: search starts at (last granted + 1) mod NPORT, pointer updated on grant; RR=0: lowest index wins.
REQ-015 Grant cycle G latches addr, wdata, type, port index; k = 1/2/4 bytes by size; IDLE->XFER.
REQ-016 XFER: cycle G+1+i drives mem_a = addr+i (32-bit wrap), i = 0..k-1; stores drive mem_wr=1, mem_dout = wdata[8i+7:8i].
REQ-017 Loads: byte i captured from mem_din at end of cycle G+2+i; after byte k-1 addressed, XFER->TAIL; TAIL captures final byte.
REQ-018 Load completion: resp_valid[port] high for exactly one cycle G+k+2; resp_data = assembled little-endian value, sign-extended from bit 8k-1 when unsigned=0, zero-extended otherwise; FSM in IDLE that cycle.
REQ-019 Store completion: resp_valid[port] high in cycle G+k+1; resp_data = 0; no TAIL.
REQ-020 Grant SHALL be allowed in the same cycle resp_valid is high (back-to-back, no bubble).
REQ-021 Outside XFER: mem_wr=0, mem_a=0, mem_dout=0.
REQ-022 Requester SHALL hold fields stable until its resp_valid; req_valid withdrawn before grant is legal.
REQ-023 rdy_in=0: no state change, mem_wr forced 0, mem_a held, resp_valid held.
REQ-024 clear with rdy_in=1 during a load or IDLE: abort, IDLE next cycle, no resp_valid, RR pointer kept.
REQ-025 clear during a store: store completes all k bytes and pulses resp_valid normally (no torn writes).
REQ-026 resp_data SHALL be stable only while resp_valid is high.

Reset
REQ-027 rst_in=1 SHALL force IDLE, resp_valid=0, resp_data=0, mem_wr=0, mem_a=0, mem_dout=0, RR pointer such that port 0 is searched first, capture register 0; rst_in overrides clear and rdy_in.
REQ-028 Reset mid-XFER SHALL abandon the transfer in the next cycle with no resp_valid.

Verification
REQ-029 Word load port 0 addr 0x100, memory 0x100..0x103 = 11 22 33 84 -> mem_a 0x100..0x103 in G+1..G+4, resp_valid=01 at G+6, resp_data=0x84332211.
REQ-030 Byte load signed then unsigned from data 0x80 -> resp_data 0xFFFFFF80 then 0x00000080; half store 0xBEEF to 0x200 -> writes EF, BE, resp at G+3.
REQ-031 RR=1, both ports requesting continuously -> grants alternate 0,1,0,1, no idle cycle between resp and next grant; RR=0 -> port 0 served repeatedly.
REQ-032 io_buffer_full=1, port 0 storing to 0x30000, port 1 loading 0x10 -> port 1 served first, port 0 granted the cycle after io_buffer_full falls.
REQ-033 clear at G+2 of a word load -> no resp_valid, mem_a=0 next cycle; clear at G+2 of a word store -> 4 writes complete, resp_valid at G+5.
REQ-034 rdy_in low for 3 cycles mid word load -> mem_a held, mem_wr=0, result identical and resp shifted exactly 3 cycles.

Source files
------------

// File: rtl/memctrl_nport.sv
// memctrl_nport: N-port byte-serial memory controller.
// Arbitrates between NPORT requesters (round-robin or fixed priority), then
// moves 1, 2 or 4 bytes over an 8-bit memory bus, one byte per cycle,
// little-endian.
//
// Ports
//   clk_in, rst_in    system clock, synchronous active-high reset
//   rdy_in            global enable; low freezes the controller
//   clear             pipeline flush (aborts loads, never stores)
//   mem_din           read data, valid one cycle after its address
//   mem_dout/mem_a    write byte / byte address (zero outside a transfer)
//   mem_wr            write strobe (1 = write)
//   io_buffer_full    stores into the I/O region are held off while set
//   req_*             per-port request: valid, addr, wdata,
//                     type = {store, unsigned, size[1:0]}
//   resp_valid        one-hot completion pulse
//   resp_data         load result (zero for stores)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | pick one eligible port, latch its request
// XFER  | drive one byte address per cycle (writes for stores)
// TAIL  | loads only: capture the final byte, raise the response next

module memctrl_nport #(
    parameter int         NPORT = 2,
    parameter int         RR    = 1,
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear,
    input  logic [7:0]          mem_din,
    output logic [7:0]          mem_dout,
    output logic [31:0]         mem_a,
    output logic                mem_wr,
    input  logic                io_buffer_full,
    input  logic [NPORT-1:0]    req_valid,
    input  logic [32*NPORT-1:0] req_addr,
    input  logic [32*NPORT-1:0] req_wdata,
    input  logic [4*NPORT-1:0]  req_type,
    output logic [NPORT-1:0]    resp_valid,
    output logic [31:0]         resp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  typ_q, typ_d;
    logic [1:0]  port_q, port_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] cap_q, cap_d;
    logic [3:0]  resp_vec_q, resp_vec_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        stall_q, stall_d;
    logic [7:0]  din_hold_q, din_hold_d;

    // Requests spread into fixed 4-entry arrays so the grant index can
    // address them without width games for small NPORT.
    logic [31:0] p_addr  [4];
    logic [31:0] p_wdata [4];
    logic [3:0]  p_type  [4];
    logic [3:0]  elig;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            p_addr[i]  = '0;
            p_wdata[i] = '0;
            p_type[i]  = '0;
            elig[i]    = 1'b0;
        end
        for (int i = 0; i < NPORT; i++) begin
            p_addr[i]  = req_addr[32*i +: 32];
            p_wdata[i] = req_wdata[32*i +: 32];
            p_type[i]  = req_type[4*i +: 4];
            // A store into the I/O region waits while the UART is full,
            // but never blocks other ports.
            elig[i] = req_valid[i] &&
                      !(req_type[4*i+3] && (req_addr[32*i+16 +: 2] == IO_HI) && io_buffer_full);
        end
    end

    logic       gnt_found;
    logic [1:0] gnt_idx;
    logic [1:0] cand;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 2'd0;
        for (int off = 0; off < NPORT; off++) begin
            if (RR != 0) cand = 2'((int'(ptr_q) + 1 + off) % NPORT);
            else         cand = 2'(off);
            if (!gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    logic       is_store;
    logic [2:0] last_idx;
    logic       last_byte;
    logic [1:0] cap_pos;
    logic [7:0] din_eff;

    assign is_store  = typ_q[3];
    assign last_byte = (idx_q == last_idx);
    // Byte arriving now belongs to the address driven one cycle earlier.
    assign cap_pos   = idx_q[1:0] - 2'd1;
    // After a stall the address has been held, so mem_din now reflects the
    // held address; the byte that was due is the one sampled on stall entry.
    assign din_eff   = stall_q ? din_hold_q : mem_din;

    always_comb begin
        case (typ_q[1:0])
            2'd0:    last_idx = 3'd0;
            2'd1:    last_idx = 3'd1;
            default: last_idx = 3'd3;
        endcase
    end

    logic [31:0] load_raw;
    logic [31:0] load_ext;

    always_comb begin
        load_raw = cap_q;
        load_raw[{last_idx[1:0], 3'b000} +: 8] = din_eff;
        case (typ_q[1:0])
            2'd0:    load_ext = typ_q[2] ? {24'd0, load_raw[7:0]}
                                         : {{24{load_raw[7]}}, load_raw[7:0]};
            2'd1:    load_ext = typ_q[2] ? {16'd0, load_raw[15:0]}
                                         : {{16{load_raw[15]}}, load_raw[15:0]};
            default: load_ext = load_raw;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            case (state_q)
                IDLE: if (!clear && gnt_found) state_d = XFER;
                XFER: begin
                    if (clear && !is_store) state_d = IDLE;
                    else if (last_byte)     state_d = is_store ? IDLE : TAIL;
                end
                TAIL:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        if (state_q == XFER) begin
            mem_a = addr_q + {29'd0, idx_q};
            if (is_store) begin
                mem_wr   = rdy_in;
                mem_dout = wdata_q[{idx_q[1:0], 3'b000} +: 8];
            end
        end
    end

    // Datapath next values
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        typ_d       = typ_q;
        port_d      = port_q;
        idx_d       = idx_q;
        cap_d       = cap_q;
        resp_vec_d  = resp_vec_q;
        resp_data_d = resp_data_q;
        ptr_d       = ptr_q;
        stall_d     = !rdy_in;
        din_hold_d  = din_hold_q;
        if (!rdy_in) begin
            if (!stall_q) din_hold_d = mem_din;
        end else begin
            resp_vec_d = '0;
            case (state_q)
                IDLE: begin
                    if (!clear && gnt_found) begin
                        addr_d  = p_addr[gnt_idx];
                        wdata_d = p_wdata[gnt_idx];
                        typ_d   = p_type[gnt_idx];
                        port_d  = gnt_idx;
                        ptr_d   = gnt_idx;
                        idx_d   = 3'd0;
                        cap_d   = '0;
                    end
                end
                XFER: begin
                    if (!(clear && !is_store)) begin
                        idx_d = idx_q + 3'd1;
                        if (!is_store && (idx_q != 3'd0))
                            cap_d[{cap_pos, 3'b000} +: 8] = din_eff;
                        if (is_store && last_byte) begin
                            resp_vec_d[port_q] = 1'b1;
                            resp_data_d        = '0;
                        end
                    end
                end
                TAIL: begin
                    if (!clear) begin
                        resp_vec_d[port_q] = 1'b1;
                        resp_data_d        = load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            typ_q       <= '0;
            port_q      <= '0;
            idx_q       <= '0;
            cap_q       <= '0;
            resp_vec_q  <= '0;
            resp_data_q <= '0;
            ptr_q       <= 2'(NPORT - 1);
            stall_q     <= 1'b0;
            din_hold_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            typ_q       <= typ_d;
            port_q      <= port_d;
            idx_q       <= idx_d;
            cap_q       <= cap_d;
            resp_vec_q  <= resp_vec_d;
            resp_data_q <= resp_data_d;
            ptr_q       <= ptr_d;
            stall_q     <= stall_d;
            din_hold_q  <= din_hold_d;
        end
    end

    assign resp_valid = resp_vec_q[NPORT-1:0];
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_memctrl_nport.sv
// Directed bench for memctrl_nport: a round-robin instance with a small
// read-only memory model, plus a fixed-priority instance on the same
// request bus used only for the arbitration comparison.

module tb_memctrl_nport;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [1:0]  req_valid;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_type;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;

    logic [7:0]  fp_dout;
    logic [31:0] fp_a;
    logic        fp_wr;
    logic [1:0]  fp_resp_valid;
    logic [31:0] fp_resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    memctrl_nport #(.NPORT(2), .RR(1), .IO_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
        .resp_valid(resp_valid), .resp_data(resp_data)
    );

    memctrl_nport #(.NPORT(2), .RR(0), .IO_HI(2'b11)) dut_fp (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .mem_din(8'h00), .mem_dout(fp_dout), .mem_a(fp_a), .mem_wr(fp_wr),
        .io_buffer_full(io_buffer_full),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
        .resp_valid(fp_resp_valid), .resp_data(fp_resp_data)
    );

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0010: rom = 8'h3C;
            32'h0000_0100: rom = 8'h11;
            32'h0000_0101: rom = 8'h22;
            32'h0000_0102: rom = 8'h33;
            32'h0000_0103: rom = 8'h84;
            32'h0000_0180: rom = 8'h80;
            default:       rom = 8'h00;
        endcase
    endfunction

    // Synchronous read: data for the address seen at an edge appears after it.
    always @(posedge clk_in) mem_din <= rom(mem_a);

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] t);
        req_valid[p]        = v;
        req_addr[32*p +: 32]  = a;
        req_wdata[32*p +: 32] = d;
        req_type[4*p +: 4]    = t;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        req_valid = '0; req_addr = '0; req_wdata = '0; req_type = '0;
        tick();
        tick();

        // Reset state
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        rst_in = 1'b0;

        // Word load, port 0, 0x100 (cycle G)
        set_port(0, 1'b1, 32'h100, 32'h0, 4'b0010);
        #1 check("wl_idle_a", mem_a, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wl_addr", mem_a, 32'h100 + 32'(i));
            check("wl_wr", 32'(mem_wr), 32'h0);
        end
        tick(); // G+5 tail
        check("wl_tail_a", mem_a, 32'h0);
        check("wl_tail_resp", 32'(resp_valid), 32'h0);
        tick(); // G+6
        check("wl_resp", 32'(resp_valid), 32'h1);
        check("wl_data", resp_data, 32'h8433_2211);
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("wl_resp_pulse", 32'(resp_valid), 32'h0);

        // Signed byte load, then unsigned back-to-back in the response cycle
        set_port(0, 1'b1, 32'h180, 32'h0, 4'b0000);
        tick();
        check("bl_addr", mem_a, 32'h180);
        tick();
        tick();
        check("bls_resp", 32'(resp_valid), 32'h1);
        check("bls_data", resp_data, 32'hFFFF_FF80);
        set_port(0, 1'b1, 32'h180, 32'h0, 4'b0100);
        tick();
        check("blu_no_bubble_a", mem_a, 32'h180);
        tick();
        tick();
        check("blu_resp", 32'(resp_valid), 32'h1);
        check("blu_data", resp_data, 32'h0000_0080);
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Half store 0xBEEF to 0x200 from port 1
        set_port(1, 1'b1, 32'h200, 32'h0000_BEEF, 4'b1001);
        tick();
        check("hs_wr0", 32'(mem_wr), 32'h1);
        check("hs_a0", mem_a, 32'h200);
        check("hs_d0", 32'(mem_dout), 32'hEF);
        tick();
        check("hs_wr1", 32'(mem_wr), 32'h1);
        check("hs_a1", mem_a, 32'h201);
        check("hs_d1", 32'(mem_dout), 32'hBE);
        tick();
        check("hs_resp", 32'(resp_valid), 32'h2);
        check("hs_data", resp_data, 32'h0);
        check("hs_wr_done", 32'(mem_wr), 32'h0);
        set_port(1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // I/O store held off while the UART buffer is full
        io_buffer_full = 1'b1;
        set_port(0, 1'b1, 32'h0003_0000, 32'h5A, 4'b1000);
        set_port(1, 1'b1, 32'h10, 32'h0, 4'b0100);
        tick();
        check("io_skip_a", mem_a, 32'h10);
        check("io_skip_wr", 32'(mem_wr), 32'h0);
        tick();
        tick();
        check("io_p1_resp", 32'(resp_valid), 32'h2);
        check("io_p1_data", resp_data, 32'h3C);
        set_port(1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("io_blocked_a", mem_a, 32'h0);
        io_buffer_full = 1'b0;
        tick();
        check("io_p0_a", mem_a, 32'h0003_0000);
        check("io_p0_wr", 32'(mem_wr), 32'h1);
        check("io_p0_d", 32'(mem_dout), 32'h5A);
        tick();
        check("io_p0_resp", 32'(resp_valid), 32'h1);
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Clear at G+2 of a word load
        set_port(0, 1'b1, 32'h100, 32'h0, 4'b0010);
        tick();
        tick();
        check("clr_ld_a", mem_a, 32'h101);
        clear = 1'b1;
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("clr_ld_a_next", mem_a, 32'h0);
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("clr_ld_no_resp", 32'(resp_valid), 32'h0);
        end

        // Clear at G+2 of a word store
        set_port(0, 1'b1, 32'h300, 32'hA1B2_C3D4, 4'b1010);
        tick();
        check("clr_st_d0", 32'(mem_dout), 32'hD4);
        tick();
        check("clr_st_d1", 32'(mem_dout), 32'hC3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_st_wr2", 32'(mem_wr), 32'h1);
        check("clr_st_a2", mem_a, 32'h302);
        check("clr_st_d2", 32'(mem_dout), 32'hB2);
        tick();
        check("clr_st_a3", mem_a, 32'h303);
        check("clr_st_d3", 32'(mem_dout), 32'hA1);
        tick();
        check("clr_st_resp", 32'(resp_valid), 32'h1);
        check("clr_st_wr_done", 32'(mem_wr), 32'h0);
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // rdy_in low for three cycles in the middle of a word load
        set_port(0, 1'b1, 32'h100, 32'h0, 4'b0010);
        tick();
        tick();
        check("stl_a_pre", mem_a, 32'h101);
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stl_a_held", mem_a, 32'h101);
            check("stl_wr", 32'(mem_wr), 32'h0);
        end
        tick(); // G+5
        rdy_in = 1'b1;
        check("stl_a_resume", mem_a, 32'h101);
        tick();
        check("stl_a2", mem_a, 32'h102);
        tick();
        check("stl_a3", mem_a, 32'h103);
        tick();
        check("stl_tail_resp", 32'(resp_valid), 32'h0);
        tick(); // G+9
        check("stl_resp", 32'(resp_valid), 32'h1);
        check("stl_data", resp_data, 32'h8433_2211);
        rdy_in = 1'b0;
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("stl_resp_held", 32'(resp_valid), 32'h1);
        rdy_in = 1'b1;
        tick();
        check("stl_resp_end", 32'(resp_valid), 32'h0);

        // One-cycle stall on a byte store suppresses the strobe
        set_port(0, 1'b1, 32'h210, 32'h77, 4'b1000);
        tick();
        rdy_in = 1'b0;
        #1;
        check("sst_wr_off", 32'(mem_wr), 32'h0);
        check("sst_a", mem_a, 32'h210);
        tick();
        rdy_in = 1'b1;
        #1;
        check("sst_wr_on", 32'(mem_wr), 32'h1);
        check("sst_d", 32'(mem_dout), 32'h77);
        tick();
        check("sst_resp", 32'(resp_valid), 32'h1);
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Arbitration: both ports loading continuously
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        set_port(0, 1'b1, 32'h100, 32'h0, 4'b0100);
        set_port(1, 1'b1, 32'h101, 32'h0, 4'b0100);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 4) check("rr_no_bubble_a", mem_a, 32'h101);
            if (c % 3 == 0) begin
                check("rr_resp", 32'(resp_valid), ((c / 3) % 2 == 1) ? 32'h1 : 32'h2);
                check("rr_data", resp_data, ((c / 3) % 2 == 1) ? 32'h11 : 32'h22);
                check("fp_resp", 32'(fp_resp_valid), 32'h1);
            end
        end
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Reset in the middle of a transfer, with rdy_in low
        set_port(0, 1'b1, 32'h100, 32'h0, 4'b0010);
        tick();
        tick();
        rst_in = 1'b1;
        rdy_in = 1'b0;
        tick();
        check("rstx_a", mem_a, 32'h0);
        check("rstx_resp", 32'(resp_valid), 32'h0);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstx_no_resp", 32'(resp_valid), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
